// File: rtl/inst_fetch_unit.sv
// ============================================================================
// inst_fetch_unit
// ----------------------------------------------------------------------------
// Instruction fetch stage of the multi-cycle core.  Sits downstream of the
// program counter: takes the one-cycle fetch pulse plus address from the PC
// stage, issues a single read request to instruction memory, waits a variable
// number of cycles for the returned word and registers the 32-bit instruction
// together with its RV64 decode fields for the controller and decoder.  A
// watchdog abandons fetches whose memory response never arrives and raises a
// sticky error flag.
//
// Handshake semantics (there is no back-pressure anywhere in this block):
//   every *_valid signal is a single-cycle pulse that qualifies its data on
//   that cycle only.  i_pc_valid is consumed only while idle; pulses that
//   arrive while a fetch is in flight are dropped.  i_mem_inst_valid is
//   consumed only while waiting for a response; anything else (including a
//   response in the request cycle or after a timeout) is dropped.
//
// Ports
//   i_clk             clock, all state updates on the rising edge
//   i_rst_n           asynchronous active-low reset
//   i_pc_addr         fetch address from the PC stage
//   i_pc_valid        one-cycle fetch pulse from the PC stage
//   o_mem_addr        address presented to instruction memory
//   o_mem_valid       one-cycle read request to instruction memory
//   i_mem_inst        instruction word returned by memory
//   i_mem_inst_valid  qualifies i_mem_inst for one cycle
//   o_inst            registered instruction, held until the next capture
//   o_inst_pc         address the held instruction was fetched from
//   o_inst_valid      one-cycle pulse: new instruction available
//   o_opcode .. o_funct7  RV decode fields, pure slices of o_inst
//   o_busy            high while a request is outstanding (REQ / WAIT)
//   o_fetch_err       sticky timeout flag, cleared by the next accepted fetch
//   o_dbg_state       current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE)
//
// Parameters
//   DATA_W   address width, matches the PC stage
//   TIMEOUT  maximum number of WAIT cycles before a fetch is abandoned,
//            legal range 1..255 (the watchdog counter is 8 bits)
// ============================================================================
module inst_fetch_unit #(
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic [DATA_W-1:0] i_pc_addr,
    input  logic              i_pc_valid,

    output logic [DATA_W-1:0] o_mem_addr,
    output logic              o_mem_valid,
    input  logic [31:0]       i_mem_inst,
    input  logic              i_mem_inst_valid,

    output logic [31:0]       o_inst,
    output logic [DATA_W-1:0] o_inst_pc,
    output logic              o_inst_valid,
    output logic [6:0]        o_opcode,
    output logic [4:0]        o_rd,
    output logic [2:0]        o_funct3,
    output logic [4:0]        o_rs1,
    output logic [4:0]        o_rs2,
    output logic [6:0]        o_funct7,

    output logic              o_busy,
    output logic              o_fetch_err,
    output logic [1:0]        o_dbg_state
);

    // ------------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [7:0] CNT_MAX     = 8'hFF;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t            state_q,      state_d;
    logic [7:0]        cnt_q,        cnt_d;
    logic [DATA_W-1:0] pc_q,         pc_d;
    logic [DATA_W-1:0] mem_addr_q,   mem_addr_d;
    logic              mem_valid_q,  mem_valid_d;
    logic [31:0]       inst_q,       inst_d;
    logic [DATA_W-1:0] inst_pc_q,    inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              busy_q,       busy_d;
    logic              fetch_err_q,  fetch_err_d;

    // ------------------------------------------------------------------------
    // Shared decode of the current cycle
    // ------------------------------------------------------------------------
    logic       accept_fetch;   // idle and the PC stage is asking for a fetch
    logic       resp_hit;       // memory answered while we are waiting
    logic [7:0] cnt_inc;        // saturating increment of the watchdog
    logic       timeout_hit;    // last permitted WAIT cycle passed silently

    always_comb begin
        accept_fetch = (state_q == S_IDLE) && i_pc_valid;
        resp_hit     = (state_q == S_WAIT) && i_mem_inst_valid;
        cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + 8'd1);
        // The counter holds the number of silent WAIT cycles already spent.
        // When this cycle would bring it to TIMEOUT the fetch is abandoned.
        // A response on that very cycle takes priority (resp_hit excluded).
        timeout_hit  = (state_q == S_WAIT) && !i_mem_inst_valid &&
                       (cnt_inc >= TIMEOUT_CNT);
    end

    // ------------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept_fetch) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (resp_hit) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM process 3: output / datapath next values
    // Every output is a flop, so the pulses are scheduled one cycle ahead:
    // o_mem_valid is set on the edge entering REQ, o_inst_valid on the edge
    // entering DONE.
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_d        = cnt_q;
        pc_d         = pc_q;
        mem_addr_d   = mem_addr_q;
        mem_valid_d  = 1'b0;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = 1'b0;
        fetch_err_d  = fetch_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept_fetch) begin
                    mem_addr_d  = i_pc_addr;
                    pc_d        = i_pc_addr;
                    mem_valid_d = 1'b1;
                    // A fresh fetch starts with a clean error flag.
                    fetch_err_d = 1'b0;
                end
            end
            S_REQ: begin
                cnt_d = 8'd0;
            end
            S_WAIT: begin
                if (resp_hit) begin
                    inst_d       = i_mem_inst;
                    inst_pc_d    = pc_q;
                    inst_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) begin
                        fetch_err_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                // Nothing to compute: the o_inst_valid pulse is already
                // showing and the FSM returns to IDLE.
            end
            default: begin
            end
        endcase

        // Busy reflects the state we are about to be in, so it is a plain
        // flop and drops in the same cycle the timeout error rises.
        busy_d = (state_d == S_REQ) || (state_d == S_WAIT);
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q        <= 8'd0;
            pc_q         <= '0;
            mem_addr_q   <= '0;
            mem_valid_q  <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            pc_q         <= pc_d;
            mem_addr_q   <= mem_addr_d;
            mem_valid_q  <= mem_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            busy_q       <= busy_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_valid  = mem_valid_q;
    assign o_inst       = inst_q;
    assign o_inst_pc    = inst_pc_q;
    assign o_inst_valid = inst_valid_q;
    assign o_busy       = busy_q;
    assign o_fetch_err  = fetch_err_q;
    assign o_dbg_state  = state_q;

    // Decode fields are slices of the held instruction, stable until the
    // next capture.
    assign o_opcode = inst_q[6:0];
    assign o_rd     = inst_q[11:7];
    assign o_funct3 = inst_q[14:12];
    assign o_rs1    = inst_q[19:15];
    assign o_rs2    = inst_q[24:20];
    assign o_funct7 = inst_q[31:25];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// tb_inst_fetch_unit
// ----------------------------------------------------------------------------
// Self-checking bench for inst_fetch_unit (TIMEOUT = 4).  A transaction-level
// model tracks the age of the fetch in flight (edges since the pulse was
// accepted) and derives every registered output from that age; a compare
// process checks the DUT against it on every falling edge.  Directed scenarios
// add hand-computed literal checks, followed by a randomized phase.
// ============================================================================
module tb_inst_fetch_unit;

    localparam int DW = 64;
    localparam int TO = 4;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------------
    logic [DW-1:0] pc_addr = '0;
    logic          pc_valid = 1'b0;
    logic [DW-1:0] mem_addr;
    logic          mem_valid;
    logic [31:0]   mem_inst = '0;
    logic          mem_inst_valid = 1'b0;
    logic [31:0]   inst;
    logic [DW-1:0] inst_pc;
    logic          inst_valid;
    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [2:0]    funct3;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [6:0]    funct7;
    logic          busy;
    logic          fetch_err;
    logic [1:0]    dbg_state;

    inst_fetch_unit #(
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_pc_addr        (pc_addr),
        .i_pc_valid       (pc_valid),
        .o_mem_addr       (mem_addr),
        .o_mem_valid      (mem_valid),
        .i_mem_inst       (mem_inst),
        .i_mem_inst_valid (mem_inst_valid),
        .o_inst           (inst),
        .o_inst_pc        (inst_pc),
        .o_inst_valid     (inst_valid),
        .o_opcode         (opcode),
        .o_rd             (rd),
        .o_funct3         (funct3),
        .o_rs1            (rs1),
        .o_rs2            (rs2),
        .o_funct7         (funct7),
        .o_busy           (busy),
        .o_fetch_err      (fetch_err),
        .o_dbg_state      (dbg_state)
    );

    // ------------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model: a fetch is described by the number of clock edges
    // since its pulse was accepted.  Edge 1 ends the request cycle, edge n>=2
    // ends waiting cycle n-1.  Waiting cycle TO without a response abandons
    // the fetch; a response during any waiting cycle captures the word and
    // the following cycle announces it.
    // ------------------------------------------------------------------------
    logic [DW-1:0] exp_mem_addr   = '0;
    logic          exp_mem_valid  = 1'b0;
    logic [31:0]   exp_inst       = '0;
    logic [DW-1:0] exp_inst_pc    = '0;
    logic          exp_inst_valid = 1'b0;
    logic          exp_busy       = 1'b0;
    logic          exp_err        = 1'b0;

    bit            m_active = 1'b0;   // request issued, waiting for memory
    bit            m_done   = 1'b0;   // announcing a captured word this cycle
    int            m_age    = 0;
    logic [DW-1:0] m_addr   = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active       = 1'b0;
                m_done         = 1'b0;
                m_age          = 0;
                exp_mem_addr   = '0;
                exp_mem_valid  = 1'b0;
                exp_inst       = '0;
                exp_inst_pc    = '0;
                exp_inst_valid = 1'b0;
                exp_busy       = 1'b0;
                exp_err        = 1'b0;
            end else begin
                exp_mem_valid  = 1'b0;
                exp_inst_valid = 1'b0;
                if (m_done) begin
                    m_done = 1'b0;
                end else if (m_active) begin
                    m_age++;
                    if (m_age >= 2) begin
                        if (mem_inst_valid) begin
                            exp_inst       = mem_inst;
                            exp_inst_pc    = m_addr;
                            exp_inst_valid = 1'b1;
                            m_active       = 1'b0;
                            m_done         = 1'b1;
                        end else if (m_age - 1 == TO) begin
                            exp_err  = 1'b1;
                            m_active = 1'b0;
                        end
                    end
                end else if (pc_valid) begin
                    m_active      = 1'b1;
                    m_age         = 0;
                    m_addr        = pc_addr;
                    exp_mem_addr  = pc_addr;
                    exp_mem_valid = 1'b1;
                    exp_err       = 1'b0;
                end
                exp_busy = m_active;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Compare process: every falling edge once the first reset is released
    // ------------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                chk("mem_valid",  64'(mem_valid),  64'(exp_mem_valid));
                chk("mem_addr",   mem_addr,        exp_mem_addr);
                chk("inst",       64'(inst),       64'(exp_inst));
                chk("inst_pc",    inst_pc,         exp_inst_pc);
                chk("inst_valid", 64'(inst_valid), 64'(exp_inst_valid));
                chk("busy",       64'(busy),       64'(exp_busy));
                chk("fetch_err",  64'(fetch_err),  64'(exp_err));
                chk("opcode",     64'(opcode),     64'(exp_inst & 32'h7f));
                chk("rd",         64'(rd),         64'((exp_inst >> 7) & 32'h1f));
                chk("funct3",     64'(funct3),     64'((exp_inst >> 12) & 32'h7));
                chk("rs1",        64'(rs1),        64'((exp_inst >> 15) & 32'h1f));
                chk("rs2",        64'(rs2),        64'((exp_inst >> 20) & 32'h1f));
                chk("funct7",     64'(funct7),     64'((exp_inst >> 25) & 32'h7f));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver tasks (inputs change on the falling edge)
    // ------------------------------------------------------------------------
    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Pulse a fetch, answer it k waiting cycles later, return in DONE cycle.
    task automatic fetch_resp(input logic [DW-1:0] addr, input int k, input logic [31:0] word);
        next_cycle();
        pc_valid = 1'b1;
        pc_addr  = addr;
        next_cycle();
        pc_valid = 1'b0;
        for (int i = 0; i < k; i++) next_cycle();
        mem_inst_valid = 1'b1;
        mem_inst       = word;
        next_cycle();
        mem_inst_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_valid"},  64'(mem_valid),  64'd0);
        chk({tag, "_mem_addr"},   mem_addr,        64'd0);
        chk({tag, "_inst"},       64'(inst),       64'd0);
        chk({tag, "_inst_pc"},    inst_pc,         64'd0);
        chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
        chk({tag, "_busy"},       64'(busy),       64'd0);
        chk({tag, "_fetch_err"},  64'(fetch_err),  64'd0);
        chk({tag, "_opcode"},     64'(opcode),     64'd0);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        // Reset then idle
        repeat (3) next_cycle();
        rst_n = 1'b1;
        check_all_zero("reset");
        check_en = 1'b1;
        repeat (4) next_cycle();
        chk("idle_no_req", 64'(mem_valid), 64'd0);

        // Basic fetch: 0x00A30293 = addi x5, x6, 10
        next_cycle();
        pc_valid = 1'b1;
        pc_addr  = 64'h40;
        next_cycle();
        pc_valid = 1'b0;
        chk("basic_req_valid", 64'(mem_valid), 64'd1);
        chk("basic_req_addr",  mem_addr,       64'h40);
        next_cycle();
        next_cycle();
        mem_inst_valid = 1'b1;
        mem_inst       = 32'h00A30293;
        next_cycle();
        mem_inst_valid = 1'b0;
        chk("basic_inst",   64'(inst),       64'h00A30293);
        chk("basic_valid",  64'(inst_valid), 64'd1);
        chk("basic_opcode", 64'(opcode),     64'h13);
        chk("basic_rd",     64'(rd),         64'd5);
        chk("basic_funct3", 64'(funct3),     64'd0);
        chk("basic_rs1",    64'(rs1),        64'd6);
        chk("basic_rs2",    64'(rs2),        64'd10);
        chk("basic_funct7", 64'(funct7),     64'd0);
        chk("basic_pc",     inst_pc,         64'h40);
        next_cycle();
        chk("basic_pulse_end", 64'(inst_valid), 64'd0);

        // Busy drop: second pulse during WAIT is ignored
        next_cycle();
        pc_valid = 1'b1;
        pc_addr  = 64'h44;
        next_cycle();
        pc_valid = 1'b0;
        next_cycle();
        pc_valid = 1'b1;
        pc_addr  = 64'h80;
        next_cycle();
        pc_valid = 1'b0;
        mem_inst_valid = 1'b1;
        mem_inst       = 32'h002081B3;
        next_cycle();
        mem_inst_valid = 1'b0;
        chk("busy_drop_pc",   inst_pc,  64'h44);
        chk("busy_drop_addr", mem_addr, 64'h44);
        chk("busy_drop_rd",   64'(rd),  64'd3);
        next_cycle();

        // Timeout: no response, error in cycle t+6
        next_cycle();
        pc_valid = 1'b1;
        pc_addr  = 64'h1000;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            pc_valid = 1'b0;
        end
        chk("timeout_err",  64'(fetch_err), 64'd1);
        chk("timeout_busy", 64'(busy),      64'd0);
        next_cycle();
        mem_inst_valid = 1'b1;
        mem_inst       = 32'hDEADBEEF;
        next_cycle();
        mem_inst_valid = 1'b0;
        chk("late_resp_dropped", 64'(inst), 64'h002081B3);

        // Next fetch clears the error; response on the 4th WAIT cycle wins
        fetch_resp(64'h2000, TO, 32'hFFF00513);
        chk("race_valid",  64'(inst_valid), 64'd1);
        chk("race_err",    64'(fetch_err),  64'd0);
        chk("race_inst",   64'(inst),       64'hFFF00513);
        chk("race_funct7", 64'(funct7),     64'h7f);
        next_cycle();

        // Reset mid-WAIT
        next_cycle();
        pc_valid = 1'b1;
        pc_addr  = 64'h3000;
        next_cycle();
        pc_valid = 1'b0;
        next_cycle();
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        next_cycle();
        mem_inst_valid = 1'b1;
        mem_inst       = 32'h12345678;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        mem_inst_valid = 1'b0;
        next_cycle();
        chk("midrst_no_valid", 64'(inst_valid), 64'd0);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            next_cycle();
            pc_valid       = ($urandom_range(0, 3) == 0);
            pc_addr        = {$urandom, $urandom};
            mem_inst_valid = ($urandom_range(0, 4) == 0);
            mem_inst       = $urandom;
        end
        next_cycle();
        pc_valid       = 1'b0;
        mem_inst_valid = 1'b0;
        repeat (8) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Downstream neighbour of the program counter in the multi-cycle core. Accepts the one-cycle fetch pulse and address produced by the PC stage and issues a single read request to instruction memory. It waits a variable number of cycles for the returned word, then registers the 32-bit instruction and its RV64 decode fields for the controller and decoder. A watchdog flags memory responses that never arrive.

## Interface
- DATA_W, 64, address width; matches the PC stage.
- TIMEOUT, 16, maximum WAIT cycles before abandoning a fetch; legal range 1..255.
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- i_pc_addr  input  DATA_W  fetch address from PC stage.
- i_pc_valid  input  1  one-cycle fetch pulse from PC stage.
- o_mem_addr  output  DATA_W  address presented to instruction memory.
- o_mem_valid  output  1  one-cycle read request to instruction memory.
- i_mem_inst  input  32  instruction word returned by memory.
- i_mem_inst_valid  input  1  qualifies i_mem_inst for one cycle.
- o_inst  output  32  registered instruction, held until the next capture.
- o_inst_pc  output  DATA_W  address the held instruction was fetched from.
- o_inst_valid  output  1  one-cycle pulse: new instruction available.
- o_opcode / o_rd / o_funct3 / o_rs1 / o_rs2 / o_funct7  output  7/5/3/5/5/7  slices of o_inst: [6:0], [11:7], [14:12], [19:15], [24:20], [31:25].
- o_busy  output  1  high in REQ and WAIT.
- o_fetch_err  output  1  sticky timeout flag.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on i_pc_valid=1, register i_pc_addr into o_mem_addr and the internal pc latch, clear o_fetch_err, go to REQ.
- REQ: o_mem_valid=1 for exactly this one cycle; clear the watchdog counter; go to WAIT.
- WAIT: if i_mem_inst_valid=1, register i_mem_inst into o_inst and the pc latch into o_inst_pc, then go to DONE. Otherwise increment the counter. When the counter reaches TIMEOUT with no response, set o_fetch_err=1 and go to IDLE without changing o_inst.
- DONE: o_inst_valid=1 for this one cycle; go to IDLE.
- Decode fields are pure slices of the o_inst register, so they are stable from DONE until the next capture.
- i_pc_valid in REQ, WAIT or DONE: ignored. There is no queueing and no address change.
- i_mem_inst_valid outside WAIT, including in REQ: ignored. Late responses after a timeout are dropped.
- Response arriving on the same cycle the counter reaches TIMEOUT: the data wins. The instruction is captured and o_fetch_err stays 0.
- Counter width is 8 bits and saturates; no wrap is possible within the legal TIMEOUT range.
- Reset mid-operation: return to IDLE at once. Any outstanding memory response is ignored.

## Timing
- Reset values: o_mem_addr=0, o_mem_valid=0, o_inst=0 (all decode fields 0), o_inst_pc=0, o_inst_valid=0, o_busy=0, o_fetch_err=0, FSM=IDLE, counter=0.
- All outputs are registered or slices of registers; there is no combinational path from input to output.
- i_pc_valid sampled at edge t → o_mem_valid=1 and o_mem_addr valid during cycle t+1.
- Memory response is earliest at cycle t+2, i.e. the first WAIT cycle. A response sampled at edge t+1+k (k≥1) gives o_inst_valid=1 in cycle t+2+k.
- Minimum fetch latency is 3 cycles from the pc pulse to o_inst_valid. Back-to-back fetches are possible every 4 cycles; i_pc_valid is accepted again from the cycle after DONE.
- Timeout: with no response, o_fetch_err rises in cycle t+2+TIMEOUT. From that same cycle o_busy=0 and a new pulse is accepted.

## Test plan
- Reset then idle: hold i_rst_n=0 three cycles; release. Every output is 0 and o_mem_valid never pulses without i_pc_valid.
- Basic fetch: i_pc_valid with i_pc_addr=0x40; memory returns 0x00A30293 two cycles after o_mem_valid. o_mem_addr=0x40; o_inst=0x00A30293, o_opcode=0x13, o_rd=5, o_funct3=0, o_rs1=6, o_rs2=10, o_funct7=0, o_inst_pc=0x40; o_inst_valid is a single-cycle pulse.
- Busy drop: second i_pc_valid with addr 0x80 during WAIT of a fetch to 0x44. Only one o_mem_valid pulse; o_inst_pc=0x44.
- Timeout: TIMEOUT=4, no response. o_fetch_err=1 in cycle t+6 and no o_inst_valid. A response injected one cycle later is ignored. The next i_pc_valid clears o_fetch_err.
- Boundary race: response arrives on exactly the 4th WAIT cycle (TIMEOUT=4). The instruction is captured and o_fetch_err=0.
- Reset mid-WAIT: assert i_rst_n=0 during WAIT. All outputs are 0 asynchronously. A following response produces no o_inst_valid.
